// File: rtl/hazard_tracker_if.sv
// Decode-side hazard inputs plus the forwarding tags, stall/flush controls and counters.
// The master drives decode and branch state; the slave (hazard_tracker) returns the controls.
interface hazard_tracker_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  Valid_ID;
  logic [REG_ADDR_W-1:0] Rs1_ID;
  logic [REG_ADDR_W-1:0] Rs2_ID;
  logic                  Uses_Rs1_ID;
  logic                  Uses_Rs2_ID;
  logic [REG_ADDR_W-1:0] Rd_ID;
  logic                  RegWrite_ID;
  logic                  MemRead_ID;
  logic                  Branch_Taken_EX;

  logic [REG_ADDR_W-1:0] Rd_ID_EX;
  logic [REG_ADDR_W-1:0] Rd_EX_MEM;
  logic [REG_ADDR_W-1:0] Rd_MEM_WB;
  logic                  RegWrite_EX_MEM;
  logic                  RegWrite_MEM_WB;
  logic                  Stall;
  logic                  Flush_IF_ID;
  logic                  Flush_ID_EX;
  logic [CNT_W-1:0]      Stall_Count;
  logic [CNT_W-1:0]      Flush_Count;

  modport master (
    output Valid_ID, Rs1_ID, Rs2_ID, Uses_Rs1_ID, Uses_Rs2_ID,
           Rd_ID, RegWrite_ID, MemRead_ID, Branch_Taken_EX,
    input  Rd_ID_EX, Rd_EX_MEM, Rd_MEM_WB, RegWrite_EX_MEM, RegWrite_MEM_WB,
           Stall, Flush_IF_ID, Flush_ID_EX, Stall_Count, Flush_Count
  );

  modport slave (
    input  Valid_ID, Rs1_ID, Rs2_ID, Uses_Rs1_ID, Uses_Rs2_ID,
           Rd_ID, RegWrite_ID, MemRead_ID, Branch_Taken_EX,
    output Rd_ID_EX, Rd_EX_MEM, Rd_MEM_WB, RegWrite_EX_MEM, RegWrite_MEM_WB,
           Stall, Flush_IF_ID, Flush_ID_EX, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_tracker.sv
// Control-tag pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall and branch flush generation.
// Tags advance one stage per cycle; Stall/Flush are combinational; counters saturate.
module hazard_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_tracker_if.slave  bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  valid;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  tag_t             id_ex_q, id_ex_d;
  tag_t             ex_mem_q, ex_mem_d;
  tag_t             mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall;
  logic flush_if_id;
  logic flush_id_ex;

  always_comb begin
    load_use    = 1'b0;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    id_ex_d     = '{rd:        bus.Rd_ID,
                    reg_write: bus.RegWrite_ID & bus.Valid_ID,
                    mem_read:  bus.MemRead_ID & bus.Valid_ID,
                    valid:     bus.Valid_ID};
    ex_mem_d    = id_ex_q;
    mem_wb_d    = ex_mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // x0 is never a real producer, so a load to x0 must not stall.
    load_use = bus.Valid_ID && id_ex_q.mem_read && id_ex_q.valid && (id_ex_q.rd != '0) &&
               ((bus.Uses_Rs1_ID && (bus.Rs1_ID == id_ex_q.rd)) ||
                (bus.Uses_Rs2_ID && (bus.Rs2_ID == id_ex_q.rd)));

    if (rst_n) begin
      if (bus.Branch_Taken_EX) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        id_ex_d     = BUBBLE;
      end else if (load_use) begin
        stall       = 1'b1;
        flush_id_ex = 1'b1;
        id_ex_d     = BUBBLE;
      end

      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (bus.Branch_Taken_EX && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q     <= BUBBLE;
      ex_mem_q    <= BUBBLE;
      mem_wb_q    <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      ex_mem_q    <= ex_mem_d;
      mem_wb_q    <= mem_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.Rd_ID_EX        = id_ex_q.rd;
  assign bus.Rd_EX_MEM       = ex_mem_q.rd;
  assign bus.RegWrite_EX_MEM = ex_mem_q.reg_write;
  assign bus.Rd_MEM_WB       = mem_wb_q.rd;
  assign bus.RegWrite_MEM_WB = mem_wb_q.reg_write;
  assign bus.Stall           = stall;
  assign bus.Flush_IF_ID     = flush_if_id;
  assign bus.Flush_ID_EX     = flush_id_ex;
  assign bus.Stall_Count     = stall_cnt_q;
  assign bus.Flush_Count     = flush_cnt_q;

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Control-tag pipeline and hazard controller for the 5-stage core, and the producer of the forwarding interface. It carries each instruction's destination register and write/load flags from decode through ID/EX, EX/MEM and MEM/WB. It drives the `Rd_*`/`RegWrite_*` signals consumed by the forwarding unit. It detects load-use hazards and taken-branch redirects, generates stall/flush controls, and keeps saturating stall/flush cycle counters.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `Valid_ID`  in  1: the ID stage holds a real instruction.
- `Rs1_ID`, `Rs2_ID`  in  REG_ADDR_W: decode-stage source registers.
- `Uses_Rs1_ID`, `Uses_Rs2_ID`  in  1: the instruction actually reads that source.
- `Rd_ID`  in  REG_ADDR_W: decode-stage destination.
- `RegWrite_ID`, `MemRead_ID`  in  1: decode-stage control.
- `Branch_Taken_EX`  in  1: the instruction in EX redirects the PC this cycle.
- `Rd_ID_EX`  out  REG_ADDR_W: ID/EX destination tag.
- `Rd_EX_MEM`, `Rd_MEM_WB`  out  REG_ADDR_W: destination tags for the forwarding unit.
- `RegWrite_EX_MEM`, `RegWrite_MEM_WB`  out  1: write flags for the forwarding unit.
- `Stall`  out  1: hold PC and IF/ID.
- `Flush_IF_ID`  out  1: kill the instruction in IF/ID.
- `Flush_ID_EX`  out  1: insert a bubble into ID/EX.
- `Stall_Count`, `Flush_Count`  out  CNT_W: saturating event counters.

## Operation
- Each stage register is a tag {Rd, RegWrite, MemRead, Valid}.
- A bubble tag is all zeros.
- Load-use hazard (`LU`) is true when all of the following hold:
  - `Valid_ID` is high.
  - The ID/EX tag has MemRead=1, Valid=1 and Rd≠0.
  - Either `Uses_Rs1_ID` is high and `Rs1_ID`==ID/EX.Rd, or `Uses_Rs2_ID` is high and `Rs2_ID`==ID/EX.Rd.
- Priority, highest first:
  1. Reset.
  2. `Branch_Taken_EX`.
  3. `LU`.
  4. Normal advance.
- Branch (`Branch_Taken_EX`=1):
  - `Flush_IF_ID`=1, `Flush_ID_EX`=1, `Stall`=0.
  - The ID/EX tag loads a bubble.
  - EX/MEM loads the current ID/EX tag, so the branch itself proceeds.
  - A simultaneous `LU` is ignored.
- Load-use (`LU` with no branch):
  - `Stall`=1, `Flush_ID_EX`=1, `Flush_IF_ID`=0.
  - The ID/EX tag loads a bubble; EX/MEM and MEM/WB advance.
  - The held instruction re-evaluates next cycle. The load is then in EX/MEM, so `LU` deasserts and the stall lasts exactly one cycle per load.
- Normal advance:
  - ID/EX loads {`Rd_ID`, `RegWrite_ID` & `Valid_ID`, `MemRead_ID` & `Valid_ID`, `Valid_ID`}.
  - EX/MEM loads ID/EX; MEM/WB loads EX/MEM.
- `Valid_ID`=0 is treated as a bubble in ID: no `LU`, and its flags are masked.
- An instruction with Rd=x0 still propagates with its RegWrite flag. It never causes `LU`, because the hazard check requires Rd≠0. The forwarding unit performs its own x0 check.
- Output mapping:
  - `Rd_ID_EX` = ID/EX.Rd.
  - `Rd_EX_MEM` = EX/MEM.Rd; `RegWrite_EX_MEM` = EX/MEM.RegWrite.
  - `Rd_MEM_WB` = MEM/WB.Rd; `RegWrite_MEM_WB` = MEM/WB.RegWrite.
- Counters:
  - `Stall_Count` increments on each cycle with `Stall`=1.
  - `Flush_Count` increments on each cycle with `Branch_Taken_EX`=1.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Tags and counters update on the rising edge of `clk`.
- `Stall`, `Flush_IF_ID` and `Flush_ID_EX` are combinational from current inputs and the ID/EX tag.
- Reset (`rst_n`=0 at an edge):
  - All tags become bubbles; both counters clear to 0.
  - While `rst_n`=0, `Stall`, `Flush_IF_ID` and `Flush_ID_EX` are forced to 0.
  - A reset in the middle of a stall or flush discards all in-flight tags; the first cycle after reset is normal advance.
- Latency for an instruction in ID at cycle n with no stall:
  - `Rd_ID_EX` is valid at n+1.
  - `Rd_EX_MEM`/`RegWrite_EX_MEM` are valid at n+2.
  - `Rd_MEM_WB`/`RegWrite_MEM_WB` are valid at n+3.
- If a load-use stall occurs at cycle n, the dependent instruction enters ID/EX at n+2.
- A counter's new value is visible the cycle after the event.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with arbitrary inputs -> every output is 0 and both counters are 0.
- Propagation: ID instruction with `Rd_ID`=7, `RegWrite_ID`=1, valid at cycle 0, then bubbles -> `Rd_ID_EX`=7 at cycle 1; `Rd_EX_MEM`=7 and `RegWrite_EX_MEM`=1 at cycle 2; `Rd_MEM_WB`=7 and `RegWrite_MEM_WB`=1 at cycle 3.
- Load-use: load with Rd=5 in ID/EX, ID has `Rs1_ID`=5 and `Uses_Rs1_ID`=1 -> `Stall`=1 and `Flush_ID_EX`=1 for exactly one cycle. `Stall_Count` goes 0→1. The load reaches `Rd_EX_MEM`=5 on the following cycle.
- No false stall:
  - Load with Rd=0 and a matching source -> `Stall`=0.
  - Load with Rd=5, `Rs2_ID`=5 but `Uses_Rs2_ID`=0 -> `Stall`=0.
- Branch priority: `Branch_Taken_EX`=1 in the same cycle as a load-use condition -> `Flush_IF_ID`=1, `Flush_ID_EX`=1, `Stall`=0. `Flush_Count` increments and `Stall_Count` does not.
- Saturation: with `CNT_W`=4, force 20 stall cycles -> `Stall_Count` holds at 15.
